fp32_mul_norm_round: RTL and testbench

Normalize/round/pack stage of the single-precision floating-point multiplier. It consumes the 48-bit Vedic mantissa product and the raw exponent sum from the 32-bit exponent adder, and produces an IEEE-754 binary32 result with status flags. The block is a 2-stage pipeline with valid/ready handshakes on both sides and sits directly downstream of the exponent adder and mantissa multiplier.

---
 rtl/fp32_pkg.sv | 38 +++
 rtl/fp_round_pack.sv | 51 +++++
 rtl/fp32_mul_norm_round.sv | 103 ++++++++++
 tb/tb_fp32_mul_norm_round.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared constants, flag/class bit positions and the stage-1 payload type
// for the binary32 multiplier normalize/round/pack stage.
package fp32_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam int CLS_NAN  = 2;
  localparam int CLS_INF  = 1;
  localparam int CLS_ZERO = 0;

  typedef struct packed {
    logic                sign;
    logic signed [10:0]  e;
    logic [FP_MAN_W-1:0] m;
    logic                g;
    logic                s;
    logic [2:0]          cls;
  } s1_t;

  // Combined special class of the product; inf x zero is folded into NaN here.
  function automatic logic [2:0] special_class(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] c;
    c[CLS_NAN]  = a[CLS_NAN] | b[CLS_NAN] |
                  (a[CLS_INF] & b[CLS_ZERO]) | (a[CLS_ZERO] & b[CLS_INF]);
    c[CLS_INF]  = a[CLS_INF] | b[CLS_INF];
    c[CLS_ZERO] = a[CLS_ZERO] | b[CLS_ZERO];
    return c;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even, range check and binary32 packing.
module fp_round_pack
  import fp32_pkg::*;
(
  input  logic                sign,
  input  logic signed [10:0]  e_in,
  input  logic [FP_MAN_W-1:0] m_in,
  input  logic                g,
  input  logic                s,
  input  logic [2:0]          cls,
  output logic [31:0]         result,
  output logic [3:0]          flags
);

  logic                up;
  logic                carry;
  logic [FP_MAN_W-1:0] m_rnd;
  logic signed [10:0]  e_fin;
  logic                inexact;

  always_comb begin
    up             = g & (s | m_in[0]);
    {carry, m_rnd} = {1'b0, m_in} + {{FP_MAN_W{1'b0}}, up};
    // A carry out of the fraction leaves m_rnd at zero, i.e. significand 1.0.
    e_fin   = e_in + $signed({10'd0, carry});
    inexact = g | s;

    result = '0;
    flags  = '0;
    if (cls[CLS_NAN]) begin
      result             = FP_QNAN;
      flags[FLG_INVALID] = 1'b1;
    end else if (cls[CLS_INF]) begin
      result = {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
    end else if (cls[CLS_ZERO]) begin
      result = {sign, 31'd0};
    end else if (e_fin >= 11'sd255) begin
      result              = {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
      flags[FLG_OVERFLOW] = 1'b1;
      flags[FLG_INEXACT]  = 1'b1;
    end else if (e_fin <= 11'sd0) begin
      result               = {sign, 31'd0};
      flags[FLG_UNDERFLOW] = 1'b1;
      flags[FLG_INEXACT]   = 1'b1;
    end else begin
      result             = {sign, e_fin[FP_EXP_W-1:0], m_rnd};
      flags[FLG_INEXACT] = inexact;
    end
  end

endmodule

// File: rtl/fp32_mul_norm_round.sv
// Two-stage normalize / round-pack pipeline for the binary32 multiplier,
// with valid/ready on both sides and full-rate flow when out_ready is high.
module fp32_mul_norm_round
  import fp32_pkg::*;
#(
  parameter int N    = 32,
  parameter int BIAS = FP_BIAS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sign,
  input  logic [N-1:0] exp_sum,
  input  logic [47:0]  mant_prod,
  input  logic [2:0]   a_cls,
  input  logic [2:0]   b_cls,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  result,
  output logic [3:0]   out_flags
);

  s1_t         s1_d, s1_q;
  logic        v1_d, v1_q;
  logic        v2_d, v2_q;
  logic [31:0] result_d, result_q;
  logic [3:0]  flags_d, flags_q;
  logic [31:0] rp_result;
  logic [3:0]  rp_flags;
  logic        adv1, adv2;
  logic        msb;

  // Exponent bits above [9] carry no information from the 8-bit adder.
  generate
    if (N > 10) begin : g_exp_hi
      logic unused_exp_hi;
      assign unused_exp_hi = ^exp_sum[N-1:10];
    end
  endgenerate

  always_comb begin
    adv2 = !v2_q || out_ready;
    adv1 = !v1_q || adv2;
    msb  = mant_prod[47];

    s1_d = s1_q;
    if (adv1 && in_valid) begin
      s1_d.sign = sign;
      s1_d.e    = {1'b0, exp_sum[9:0]} - 11'(BIAS) + {10'd0, msb};
      s1_d.m    = msb ? mant_prod[46:24] : mant_prod[45:23];
      s1_d.g    = msb ? mant_prod[23] : mant_prod[22];
      s1_d.s    = msb ? (|mant_prod[22:0]) : (|mant_prod[21:0]);
      s1_d.cls  = special_class(a_cls, b_cls);
    end

    v1_d = adv1 ? in_valid : v1_q;
    v2_d = adv2 ? v1_q : v2_q;

    result_d = result_q;
    flags_d  = flags_q;
    if (adv2 && v1_q) begin
      result_d = rp_result;
      flags_d  = rp_flags;
    end
  end

  fp_round_pack u_round_pack (
    .sign   (s1_q.sign),
    .e_in   (s1_q.e),
    .m_in   (s1_q.m),
    .g      (s1_q.g),
    .s      (s1_q.s),
    .cls    (s1_q.cls),
    .result (rp_result),
    .flags  (rp_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Stage-1 payload is qualified by v1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign result    = result_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// Self-checking bench: directed vectors, randomized streaming against an
// arithmetic reference model, backpressure and mid-stream reset.
module tb_fp32_mul_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [31:0] exp_sum;
  logic [47:0] mant_prod;
  logic [2:0]  a_cls;
  logic [2:0]  b_cls;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp32_mul_norm_round #(.N(32), .BIAS(127)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp_sum   (exp_sum),
    .mant_prod (mant_prod),
    .a_cls     (a_cls),
    .b_cls     (b_cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_flags (out_flags)
  );

  // Reference: treat the product as an integer, shift to a 24-bit significand,
  // round the discarded remainder against half an ulp, then classify.
  function automatic logic [35:0] ref_model(input logic sg, input logic [31:0] es,
                                            input logic [47:0] p, input logic [2:0] ac,
                                            input logic [2:0] bc);
    logic [63:0] prod, kept, rem, half;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [7:0]  e8;
    logic [22:0] frac;
    logic        inx;
    int          sh, e;
    if (ac[2] || bc[2] || (ac[1] && bc[0]) || (ac[0] && bc[1])) begin
      res = 32'h7FC0_0000; flg = 4'b1000;
    end else if (ac[1] || bc[1]) begin
      res = {sg, 8'hFF, 23'd0}; flg = 4'b0000;
    end else if (ac[0] || bc[0]) begin
      res = {sg, 31'd0}; flg = 4'b0000;
    end else begin
      prod = {16'd0, p};
      sh   = (prod >= 64'h8000_0000_0000) ? 24 : 23;
      kept = prod >> sh;
      rem  = prod - (kept << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      e = int'(es[9:0]) - 127 + ((sh == 24) ? 1 : 0);
      if (kept >= 64'h100_0000) begin
        kept = kept >> 1;
        e    = e + 1;
      end
      if (e >= 255) begin
        res = {sg, 8'hFF, 23'd0}; flg = 4'b0101;
      end else if (e <= 0) begin
        res = {sg, 31'd0}; flg = 4'b0011;
      end else begin
        e8   = e[7:0];
        frac = kept[22:0];
        res  = {sg, e8, frac};
        flg  = {3'b000, inx};
      end
    end
    return {flg, res};
  endfunction

  task automatic gen_item(output logic sg, output logic [31:0] es, output logic [47:0] p,
                          output logic [2:0] ac, output logic [2:0] bc);
    logic [23:0] ma, mb;
    ma = {1'b1, 23'($urandom)};
    mb = ($urandom_range(0, 3) == 0) ? 24'h80_0000 : {1'b1, 23'($urandom)};
    p  = {24'd0, ma} * {24'd0, mb};
    if ($urandom_range(0, 5) == 0)
      p[23:0] = p[47] ? 24'h80_0000 : {p[23], 23'h40_0000};
    es = 32'($urandom_range(0, 510));
    if ($urandom_range(0, 3) == 0) es = es | ($urandom & 32'hFFFF_FC00);
    ac = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
    bc = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
    sg = 1'($urandom);
  endtask

  // Offers one item, waits for its result with out_ready held high.
  task automatic run_one(input logic sg, input logic [31:0] es, input logic [47:0] p,
                         input logic [2:0] ac, input logic [2:0] bc,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
    bit got;
    @(negedge clk);
    sign = sg; exp_sum = es; mant_prod = p; a_cls = ac; b_cls = bc;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    r = result; f = out_flags;
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    sign = 1'b0; exp_sum = 32'd254; mant_prod = 48'h4000_0000_0000; a_cls = '0; b_cls = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++; if (out_flags !== 4'd0) begin bad++; $display("FAIL reset_flags got=%b want=0000", out_flags); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignored_input got=%b want=0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic        sg_t [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    logic [31:0] es_t [15] = '{254, 254, 254, 254, 400, 100, 254, 254, 254, 254, 381, 127, 128,
                               32'hFFFF_FCFE, 254};
    logic [47:0] p_t  [15] = '{48'h4000_0000_0000, 48'h9000_0000_0000, 48'h4000_00C0_0000,
                               48'h4000_0040_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                               48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                               48'h7FFF_FFC0_0000, 48'h7FFF_FFC0_0000, 48'h4000_0000_0000,
                               48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000};
    logic [2:0]  ac_t [15] = '{0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 0, 0, 4};
    logic [2:0]  bc_t [15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2};
    logic [31:0] r_t  [15] = '{32'h3F80_0000, 32'h4010_0000, 32'h3F80_0002, 32'h3F80_0000,
                               32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000,
                               32'h8000_0000, 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000,
                               32'h0080_0000, 32'hBF80_0000, 32'h7FC0_0000};
    logic [3:0]  f_t  [15] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b1000,
                               4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0011, 4'b0000, 4'b0000,
                               4'b1000};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 15; i++) begin
      run_one(sg_t[i], es_t[i], p_t[i], ac_t[i], bc_t[i], r, f, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL directed_latency case=%0d got=%0d want=2", i, lat); end
      total++; if (r !== r_t[i]) begin bad++; $display("FAIL directed_result case=%0d got=%h want=%h", i, r, r_t[i]); end
      total++; if (f !== f_t[i]) begin bad++; $display("FAIL directed_flags case=%0d got=%b want=%b", i, f, f_t[i]); end
      $display("directed case=%0d result=%h flags=%b lat=%0d", i, r, f, lat);
    end
  endtask

  task automatic test_random();
    logic [35:0] q[$];
    logic [35:0] exp_v;
    logic        sg;
    logic [31:0] es;
    logic [47:0] p;
    logic [2:0]  ac, bc;
    bit          have = 1'b0;
    int          n_out = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (!have && $urandom_range(0, 3) != 0) begin
        gen_item(sg, es, p, ac, bc);
        sign = sg; exp_sum = es; mant_prod = p; a_cls = ac; b_cls = bc;
        have = 1'b1;
      end
      in_valid  = have;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_model(sign, exp_sum, mant_prod, a_cls, b_cls));
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL random_spurious got=%h want=none", result);
        end else begin
          exp_v = q.pop_front();
          if ({out_flags, result} !== exp_v) begin
            bad++;
            $display("FAIL random_result n=%0d got=%h/%b want=%h/%b", n_out, result, out_flags,
                     exp_v[31:0], exp_v[35:32]);
          end
          $display("random n=%0d result=%h flags=%b", n_out, result, out_flags);
        end
        n_out++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL random_drain_spurious got=%h want=none", result);
        end else begin
          exp_v = q.pop_front();
          if ({out_flags, result} !== exp_v) begin
            bad++;
            $display("FAIL random_drain n=%0d got=%h/%b want=%h/%b", n_out, result, out_flags,
                     exp_v[31:0], exp_v[35:32]);
          end
        end
        n_out++;
      end
      @(negedge clk);
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL random_lost got=%0d pending want=0", q.size()); end
    $display("test_random done outputs=%0d", n_out);
  endtask

  task automatic test_backpressure();
    logic        sg_a [4];
    logic [31:0] es_a [4];
    logic [47:0] p_a  [4];
    logic [2:0]  ac_a [4], bc_a [4];
    logic [35:0] exp_a [4];
    logic [31:0] snap_r = '0;
    logic [3:0]  snap_f = '0;
    bit          snap_ok = 1'b0;
    int          idx = 0, acc = 0, got = 0;
    for (int i = 0; i < 4; i++) begin
      gen_item(sg_a[i], es_a[i], p_a[i], ac_a[i], bc_a[i]);
      exp_a[i] = ref_model(sg_a[i], es_a[i], p_a[i], ac_a[i], bc_a[i]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      sign = sg_a[idx]; exp_sum = es_a[idx]; mant_prod = p_a[idx]; a_cls = ac_a[idx]; b_cls = bc_a[idx];
      #1;
      if (out_valid && !snap_ok) begin snap_r = result; snap_f = out_flags; snap_ok = 1'b1; end
      if (in_valid && in_ready) begin idx++; acc++; end
    end
    total++; if (acc != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    total++;
    if (!snap_ok || result !== snap_r || out_flags !== snap_f) begin
      bad++; $display("FAIL bp_stable got=%h/%b want=%h/%b", result, out_flags, snap_r, snap_f);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      if (idx < 4) begin
        sign = sg_a[idx]; exp_sum = es_a[idx]; mant_prod = p_a[idx]; a_cls = ac_a[idx]; b_cls = bc_a[idx];
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        total++;
        if (got >= 4) begin
          bad++; $display("FAIL bp_duplicate got=%h want=none", result);
        end else if ({out_flags, result} !== exp_a[got]) begin
          bad++;
          $display("FAIL bp_order n=%0d got=%h/%b want=%h/%b", got, result, out_flags,
                   exp_a[got][31:0], exp_a[got][35:32]);
        end
        $display("backpressure n=%0d result=%h flags=%b", got, result, out_flags);
        got++;
      end
    end
    in_valid = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got); end
  endtask

  task automatic test_reset_midstream();
    int n_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      sign = 1'b0; exp_sum = 32'd254; mant_prod = 48'h9000_0000_0000; a_cls = '0; b_cls = '0;
    end
    #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_full got=%b%b want=10", out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd0 || out_flags !== 4'd0) begin
      bad++; $display("FAIL mid_outputs got=%h/%b want=00000000/0000", result, out_flags);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) n_seen++;
    end
    total++; if (n_seen != 0) begin bad++; $display("FAIL mid_discard got=%0d want=0", n_seen); end
    $display("test_reset_midstream done");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
